bcd_up_counter_ctrl: RTL and testbench

BCD_UP_COUNTER_CTRL -- requirements
Module: bcd_up_counter_ctrl

---
 rtl/bcd_up_counter_ctrl.sv | 124 ++++++++++++
 tb/tb_bcd_up_counter_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_up_counter_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_up_counter_ctrl
//   Two-digit BCD up-counter with a run/pause/idle controller. It counts
//   divider ticks while running, wraps from {MAX_TENS,MAX_ONES} to 00, and
//   drives the enable and phase-restart signals of the external divider.
//
// Parameters
//   MAX_TENS    terminal tens digit (0-9)
//   MAX_ONES    terminal ones digit when tens == MAX_TENS (0-9)
//
// Ports
//   clk         system clock, all state updates on rising edge
//   rst_n       asynchronous active-low reset
//   tick        one-cycle count enable from the divider
//   start_stop  one-cycle pulse: IDLE->RUN, RUN->PAUSE, PAUSE->RUN
//   clear       one-cycle pulse: back to IDLE with count 00 (highest priority)
//   bcd_tens    tens digit, registered
//   bcd_ones    ones digit, registered
//   wrap        one-cycle pulse when the count rolls over to 00
//   running     high while in RUN
//   div_en      divider enable, high only in RUN
//   div_clr     one-cycle divider phase restart on IDLE->RUN
// ---------------------------------------------------------------------------
module bcd_up_counter_ctrl #(
    parameter logic [3:0] MAX_TENS = 4'd5,
    parameter logic [3:0] MAX_ONES = 4'd9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       wrap,
    output logic       running,
    output logic       div_en,
    output logic       div_clr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic       r_wrap;
    logic       r_div_clr;
    logic       w_cnt_en;
    logic       w_at_term;
    logic       w_start;

    // Ticks only count in RUN, and clear overrides everything.
    assign w_cnt_en = (r_state == RUN) && tick && !clear;
    assign w_start  = (r_state == IDLE) && start_stop && !clear;

    // Anything at or past the terminal value rolls to 00, so an
    // out-of-range value can never persist or grow.
    assign w_at_term = (r_tens > MAX_TENS) ||
                       ((r_tens == MAX_TENS) && (r_ones >= MAX_ONES));

    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = IDLE;
        end else if (start_stop) begin
            case (r_state)
                IDLE:    w_next = RUN;
                RUN:     w_next = PAUSE;
                PAUSE:   w_next = RUN;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tens    <= 4'd0;
            r_ones    <= 4'd0;
            r_wrap    <= 1'b0;
            r_div_clr <= 1'b0;
        end else begin
            r_wrap    <= 1'b0;
            // Only a fresh start restarts the divider phase; resuming from
            // PAUSE keeps the partial period already accumulated.
            r_div_clr <= w_start;
            if (clear) begin
                r_tens <= 4'd0;
                r_ones <= 4'd0;
            end else if (w_cnt_en) begin
                if (w_at_term) begin
                    r_tens <= 4'd0;
                    r_ones <= 4'd0;
                    r_wrap <= 1'b1;
                end else if (r_ones >= 4'd9) begin
                    r_ones <= 4'd0;
                    r_tens <= r_tens + 4'd1;
                end else begin
                    r_ones <= r_ones + 4'd1;
                end
            end
        end
    end

    assign bcd_tens = r_tens;
    assign bcd_ones = r_ones;
    assign wrap     = r_wrap;
    assign div_clr  = r_div_clr;
    assign running  = (r_state == RUN);
    assign div_en   = (r_state == RUN);

endmodule

// File: tb/tb_bcd_up_counter_ctrl.sv
module tb_bcd_up_counter_ctrl;

    localparam int MT   = 5;
    localparam int MO   = 9;
    localparam int TERM = MT * 10 + MO;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       start_stop;
    logic       clear;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       wrap;
    logic       running;
    logic       div_en;
    logic       div_clr;

    bcd_up_counter_ctrl #(.MAX_TENS(4'd5), .MAX_ONES(4'd9)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .start_stop (start_stop),
        .clear      (clear),
        .bcd_tens   (bcd_tens),
        .bcd_ones   (bcd_ones),
        .wrap       (wrap),
        .running    (running),
        .div_en     (div_en),
        .div_clr    (div_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int tens;
        int ones;
        int wrap;
        int run;
        int dclr;
    } exp_t;

    typedef struct {
        logic t;
        logic s;
        logic c;
        exp_t e;
    } vec_t;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;
    int   m_st;   // 0 idle, 1 run, 2 pause
    int   m_cnt;  // count as a plain integer 0..TERM

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input exp_t e);
        chk({tag, ".tens"},    int'(bcd_tens), e.tens);
        chk({tag, ".ones"},    int'(bcd_ones), e.ones);
        chk({tag, ".wrap"},    int'(wrap),     e.wrap);
        chk({tag, ".running"}, int'(running),  e.run);
        chk({tag, ".div_en"},  int'(div_en),   e.run);
        chk({tag, ".div_clr"}, int'(div_clr),  e.dclr);
    endtask

    // Drive one cycle of inputs, push the expectation, compare after the edge.
    task automatic apply(input string tag, input logic t, input logic s,
                         input logic c, input exp_t e);
        exp_t got;
        @(negedge clk);
        tick = t; start_stop = s; clear = c;
        sb.push_back(e);
        @(posedge clk);
        #1;
        tick = 1'b0; start_stop = 1'b0; clear = 1'b0;
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got = sb.pop_front();
            chk_outs(tag, got);
        end
    endtask

    // Reference model: counts as an integer, splits into digits on demand.
    task automatic step(input string tag, input logic t, input logic s, input logic c);
        exp_t e;
        e.wrap = 0;
        e.dclr = 0;
        if (c) begin
            m_st  = 0;
            m_cnt = 0;
        end else begin
            if (m_st == 1 && t) begin
                if (m_cnt == TERM) begin
                    m_cnt  = 0;
                    e.wrap = 1;
                end else begin
                    m_cnt++;
                end
            end
            if (s) begin
                if (m_st == 0) begin
                    m_st   = 1;
                    e.dclr = 1;
                end else if (m_st == 1) m_st = 2;
                else m_st = 1;
            end
        end
        e.tens = m_cnt / 10;
        e.ones = m_cnt % 10;
        e.run  = (m_st == 1) ? 1 : 0;
        apply(tag, t, s, c, e);
    endtask

    vec_t vt[12];
    exp_t zero_e;

    initial begin
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; tick = 1'b0; start_stop = 1'b0; clear = 1'b0;
        zero_e = '{tens:0, ones:0, wrap:0, run:0, dclr:0};

        // Start then ten ticks: constant expectations.
        vt[0] = '{t:1'b0, s:1'b1, c:1'b0, e:'{tens:0, ones:0, wrap:0, run:1, dclr:1}};
        for (int i = 1; i <= 10; i++)
            vt[i] = '{t:1'b1, s:1'b0, c:1'b0, e:'{tens:i/10, ones:i%10, wrap:0, run:1, dclr:0}};
        vt[11] = '{t:1'b0, s:1'b0, c:1'b0, e:'{tens:1, ones:0, wrap:0, run:1, dclr:0}};

        #12;
        chk_outs("reset", zero_e);
        @(negedge clk);
        rst_n = 1'b1;
        m_st = 0; m_cnt = 0;

        // Tick in IDLE is ignored.
        step("idle_tick", 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++)
            apply($sformatf("vec%0d", i), vt[i].t, vt[i].s, vt[i].c, vt[i].e);
        m_st = 1; m_cnt = 10;

        // Run up to terminal and wrap.
        for (int i = 0; i < 49; i++) step("to59", 1'b1, 1'b0, 1'b0);
        step("wrap", 1'b1, 1'b0, 1'b0);
        step("wrap_low", 1'b0, 1'b0, 1'b0);

        // Pause holds, resume does not pulse div_clr.
        step("clr", 1'b0, 1'b0, 1'b1);
        step("start", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 23; i++) step("to23", 1'b1, 1'b0, 1'b0);
        step("pause", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step("pause_tick", 1'b1, 1'b0, 1'b0);
        step("resume", 1'b0, 1'b1, 1'b0);
        step("tick24", 1'b1, 1'b0, 1'b0);

        // Clear wins over tick and start_stop.
        for (int i = 0; i < 13; i++) step("to37", 1'b1, 1'b0, 1'b0);
        step("clr_all", 1'b1, 1'b1, 1'b1);

        // Tick plus start_stop in RUN counts then pauses.
        step("start2", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step("to09", 1'b1, 1'b0, 1'b0);
        step("tick_pause", 1'b1, 1'b1, 1'b0);
        step("paused_hold", 1'b0, 1'b0, 1'b0);

        // Mid-run asynchronous reset at 45.
        step("resume2", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 35; i++) step("to45", 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("async_rst", zero_e);
        tick = 1'b1; start_stop = 1'b1;
        @(posedge clk);
        #1;
        chk_outs("rst_held", zero_e);
        @(negedge clk);
        rst_n = 1'b1; tick = 1'b0; start_stop = 1'b0;
        m_st = 0; m_cnt = 0;
        step("post_rst_start", 1'b0, 1'b1, 1'b0);
        step("post_rst_tick", 1'b1, 1'b0, 1'b0);

        if (sb.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_leftover: got %0d expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
